// File: rtl/nibble_serial_adder_if.sv
// Operand/result bus for nibble_serial_adder.
// Both channels use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; the source holds its payload while valid is high and ready is low.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, Sum, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, Sum, Cout, Ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit add step per clock, LSB nibble first,
// with the carry chained through a register between steps.
module nibble_serial_adder #(
    parameter int WIDTH  = 16,
    parameter int NIBBLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_adder_if.slave bus,
    output logic [1:0]           dbg_state
);

    localparam int N  = WIDTH / NIBBLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef logic [CW-1:0] step_t;
    localparam step_t LAST_STEP = step_t'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    generate
        if (NIBBLE != 4 || WIDTH < NIBBLE || (WIDTH % NIBBLE) != 0) begin : g_bad_params
            $error("nibble_serial_adder: WIDTH must be a positive multiple of NIBBLE, and NIBBLE must be 4");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic               carry_q, carry_d;
    step_t              step_q, step_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [NIBBLE-1:0]  nib_a;
    logic [NIBBLE-1:0]  nib_b;
    logic [NIBBLE:0]    nib_sum;
    logic [WIDTH-1:0]   psum_step;

    // The single 4-bit add step, applied to whichever nibble the counter selects.
    always_comb begin
        nib_a     = op_a_q[int'(step_q)*NIBBLE +: NIBBLE];
        nib_b     = op_b_q[int'(step_q)*NIBBLE +: NIBBLE];
        nib_sum   = {1'b0, nib_a} + {1'b0, nib_b} + {{NIBBLE{1'b0}}, carry_q};
        psum_step = psum_q;
        psum_step[int'(step_q)*NIBBLE +: NIBBLE] = nib_sum[NIBBLE-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            step_q  <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            step_q  <= step_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.in_valid)         state_d = S_ADD;
            S_ADD:   if (step_q == LAST_STEP)  state_d = S_DONE;
            S_DONE:  if (bus.out_ready)        state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        step_d  = step_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == S_IDLE && bus.in_valid) begin
            op_a_d  = bus.A;
            op_b_d  = bus.B;
            carry_d = bus.Cin;
            step_d  = '0;
            psum_d  = '0;
        end else if (state_q == S_ADD) begin
            psum_d  = psum_step;
            carry_d = nib_sum[NIBBLE];
            // The counter parks on the last step instead of wrapping.
            if (step_q == LAST_STEP) begin
                sum_d  = psum_step;
                cout_d = nib_sum[NIBBLE];
                ovf_d  = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                         (psum_step[WIDTH-1] != op_a_q[WIDTH-1]);
            end else begin
                step_d = step_q + step_t'(1);
            end
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE) && !rst;
        bus.out_valid = (state_q == S_DONE);
        bus.Sum       = sum_q;
        bus.Cout      = cout_q;
        bus.Ovf       = ovf_q;
        dbg_state     = state_q;
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with an arithmetic reference model
// checked every cycle, plus literal expectations per vector.
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  nibble_serial_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_adder #(.WIDTH(W), .NIBBLE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: {Sum, Cout, Ovf} from plain arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         ovf;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    s    = full[W-1:0];
    ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {s, full[W], ovf};
  endfunction

  // scoreboard
  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_res;
  bit           armed = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_res = '0;
      armed    = 1;
    end else if (armed) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          check("sb_result", {bus.Sum, bus.Cout, bus.Ovf}, exp_q[0]);
          if (bus.out_ready) last_res = exp_q.pop_front();
        end
      end else begin
        check("sb_held", {bus.Sum, bus.Cout, bus.Ovf}, last_res);
      end
    end
  end

  // driver tasks (called at posedge+1 phase)
  task automatic send_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int t = 0;
    while (!bus.in_ready && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = c;
    exp_q.push_back(model(a, b, c));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A        = W'($urandom);
    bus.B        = W'($urandom);
    bus.Cin      = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result();
    int lat = 0;
    while (!bus.out_valid && lat < 3*N + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, N);
  endtask

  task automatic check_out(input string name, input logic [W-1:0] s, input logic c, input logic o);
    check({name, "_sum"},  bus.Sum,  s);
    check({name, "_cout"}, bus.Cout, c);
    check({name, "_ovf"},  bus.Ovf,  o);
  endtask

  task automatic recv();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("valid_drop", bus.out_valid, 0);
    check("ready_after_xfer", bus.in_ready, 1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    bit           early_ready;
  } vec_t;

  vec_t vecs[5] = '{
    '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0},
    '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1},
    '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1}
  };

  initial begin
    int seen;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset asserted mid-cycle
    #13 rst = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    check_out("post_rst", 16'h0000, 1'b0, 1'b0);
    check("post_rst_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;

    // Backpressure with ignored in_valid pulse
    send_start(16'hA5A5, 16'h5A5A, 1'b1);
    wait_result();
    check_out("bp", 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 2);
      bus.A        = 16'h1111;
      bus.B        = 16'h2222;
      @(posedge clk); #1;
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check_out("bp_hold", 16'h0000, 1'b1, 1'b0);
    end
    // in_valid coincident with the output transfer must not be accepted
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("no_accept_on_xfer", bus.in_ready, 1);
    check("no_accept_valid", bus.out_valid, 0);

    // Directed vectors
    foreach (vecs[i]) begin
      send_start(vecs[i].a, vecs[i].b, vecs[i].c);
      if (vecs[i].early_ready) bus.out_ready = 1'b1;
      wait_result();
      check_out($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].ov);
      if (vecs[i].early_ready) begin
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("early_valid_drop", bus.out_valid, 0);
        check("early_ready_after", bus.in_ready, 1);
      end else begin
        recv();
      end
    end

    // Reset in the middle of ADD discards the operation
    send_start(16'h00FF, 16'h0001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check_out("midrst", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("midrst_no_valid", seen, 0);

    send_start(16'h1234, 16'h4321, 1'b0);
    wait_result();
    check_out("after_rst", 16'h5555, 1'b0, 1'b0);
    recv();

    repeat (3) @(posedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
